ysyx_22050039_decode_stage: RTL
===============================

# ysyx_22050039_decode_stage

Pipelined RV64 decode stage: it sits between IFU and EXU and replaces the purely combinational decoder with a registered, handshaked stage. It holds the GPR file and a per-register pending-write scoreboard, and stalls on RAW hazards. It forwards a writeback that lands in the same cycle. It issues one decoded instruction per cycle through a one-entry output register with valid/ready flow control and flush.

## Interface
Parameters:
- XLEN, 64, datapath and GPR width
- NR_REG, 32, number of GPRs (x0 hardwired 0)
- REG_SEL, 5, register index width, log2(NR_REG)
- MAX_INFLIGHT, 3, max issued-but-not-written-back writers per register; counter width CW = clog2(MAX_INFLIGHT+1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  IFU offers instruction
- in_ready  out  1  stage accepts this cycle
- in_inst  in  32  instruction word
- in_pc  in  XLEN  its PC
- out_valid  out  1  decoded instruction held
- out_ready  in  1  EXU consumes
- out_pc  out  XLEN  PC
- out_type  out  3  0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SYS(ebreak), 7 ILLEGAL
- out_opcode / out_funct3 / out_funct7  out  7/3/7  raw fields
- out_rd  out  REG_SEL  destination
- out_rd_wen  out  1  writes GPR
- out_pc_wen  out  1  B, JAL, JALR
- out_src1 / out_src2  out  XLEN  operands
- out_imm  out  XLEN  sign-extended immediate
- wb_valid  in  1  writeback strobe
- wb_rd  in  REG_SEL  writeback index
- wb_data  in  XLEN  writeback value
- flush  in  1  squash output register (redirect)

## Operation
- Type by opcode: 0110011/0111011 R; 0010011/0011011/0000011/1100111 I; 0100011 S; 1100011 B; 0110111/0010111 U; 1101111 J. Exact word 0x00100073 is SYS. Every other opcode or SYSTEM word is ILLEGAL.
- Immediates, sign-extended to XLEN:
  - I: inst[31:20]
  - S: {inst[31:25],inst[11:7]}
  - B: {inst[31],inst[7],inst[30:25],inst[11:8],0}
  - U: {inst[31:12],12'b0}
  - J: {inst[31],inst[19:12],inst[20],inst[30:21],0}
  - R, SYS and ILLEGAL use 0.
- Operands:
  - R, S, B: src1=x[rs1], src2=x[rs2].
  - I: src1=x[rs1], src2=imm.
  - U, J, SYS, ILLEGAL: both 0.
- out_rd_wen = (type in R, I, U, J) && rd!=0.
- Sources used: R/S/B use rs1 and rs2; I uses rs1 only. An index of 0 is never a hazard.
- GPR read is write-first. If wb_valid and wb_rd==rs, the read returns wb_data. x0 always reads 0. A write to x0 is ignored.
- Scoreboard cnt[r], CW bits:
  - +1 on out fire (out_valid&&out_ready&&out_rd_wen) for out_rd.
  - −1 on wb_valid for wb_rd.
  - Both in the same cycle for the same r: unchanged.
  - A decrement at 0 saturates at 0; the GPR write still happens.
- Stall (in_ready=0) when any of the following holds:
  - For any used source s: the output register holds an instruction with out_rd_wen && out_rd==s.
  - For any used source s: cnt[s]!=0, unless cnt[s]==1 && wb_valid && wb_rd==s (bypass).
  - rd_wen and cnt[rd] + (out_valid&&out_rd_wen&&out_rd==rd) ≥ MAX_INFLIGHT.
  - out_valid && !out_ready.
  - flush is high.
- Accept = in_valid && in_ready. The decoded fields load into the output register and out_valid←1.
- If out fires with no accept, out_valid←0.
- Flush: out_valid←0 next cycle and no accept. Writeback and scoreboard decrements are still applied. A flushed entry never incremented cnt.

## Timing
- Reset (rst=0, asynchronous): out_valid=0, all out_* = 0, all GPRs=0, all cnt=0. Reset asserted mid-operation clears everything immediately. in_ready is low while rst=0.
- Latency is 1 cycle from accept to out_valid.
- Throughput is 1 instruction per cycle with out_ready=1 and no hazards.
- Output fields stay stable while out_valid && !out_ready.
- A writeback in cycle N is visible to a decode in cycle N (bypass) and to the GPR from N+1.
- in_ready is combinational from the out_*, out_ready, wb_*, flush, in_inst and cnt signals. It has no dependency on in_valid.

## Test plan
- Reset, then offer 0x00500093 (addi x1,x0,5) with out_ready=1 → next cycle out_type=1, out_rd=1, out_rd_wen=1, src1=0, src2=5, imm=5. Then cnt[1]=1.
- Follow with 0x00108133 (add x2,x1,x1) → in_ready=0 until wb_valid, wb_rd=1, wb_data=5. In that wb cycle it is accepted by bypass, and the output shows src1=src2=5.
- Offer 0xFE000EE3 (beq x0,x0,-4) at PC 0x80000010 → out_type=3, imm=0xFFFF_FFFF_FFFF_FFFC, pc_wen=1, rd_wen=0. No stall.
- Offer 0x123451B7 (lui x3) → imm=0x0000_0000_1234_5000, rd=3. Offer 0x00100073 → type 6. Offer 0x00000000 → type 7 with rd_wen=0.
- Issue four lui x3 with no writeback at MAX_INFLIGHT=3 → the third is held in the output register and the fourth stalls. Assert flush → out_valid=0 and cnt[3] stays 2.
- Hold out_ready=0 for 3 cycles with a valid output → outputs are stable and in_ready=0. Pulse rst low mid-stall → out_valid=0, cnt=0 and x1 reads 0.

Source files
------------

// File: rtl/ysyx_22050039_decode_stage.sv
// RV64 decode stage: GPR file, pending-write scoreboard, RAW stall, one-entry output register.
// Latency: 1 cycle from accept to out_valid; 1 instr/cycle when hazard-free.
// Backpressure: in_ready drops on hazards, full-and-not-consumed output, flush or reset.
module ysyx_22050039_decode_stage #(
    parameter int XLEN         = 64,
    parameter int NR_REG       = 32,
    parameter int REG_SEL      = 5,
    parameter int MAX_INFLIGHT = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_inst,
    input  logic [XLEN-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_pc,
    output logic [2:0]         out_type,
    output logic [6:0]         out_opcode,
    output logic [2:0]         out_funct3,
    output logic [6:0]         out_funct7,
    output logic [REG_SEL-1:0] out_rd,
    output logic               out_rd_wen,
    output logic               out_pc_wen,
    output logic [XLEN-1:0]    out_src1,
    output logic [XLEN-1:0]    out_src2,
    output logic [XLEN-1:0]    out_imm,
    input  logic               wb_valid,
    input  logic [REG_SEL-1:0] wb_rd,
    input  logic [XLEN-1:0]    wb_data,
    input  logic               flush
);

    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CW:0] MAX_CNT = (CW + 1)'(MAX_INFLIGHT);

    typedef enum logic [2:0] {
        T_R   = 3'd0,
        T_I   = 3'd1,
        T_S   = 3'd2,
        T_B   = 3'd3,
        T_U   = 3'd4,
        T_J   = 3'd5,
        T_SYS = 3'd6,
        T_ILL = 3'd7
    } inst_type_t;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [2:0]         itype;
        logic [6:0]         opcode;
        logic [2:0]         funct3;
        logic [6:0]         funct7;
        logic [REG_SEL-1:0] rd;
        logic               rd_wen;
        logic               pc_wen;
        logic [XLEN-1:0]    src1;
        logic [XLEN-1:0]    src2;
        logic [XLEN-1:0]    imm;
    } dec_t;

    logic [XLEN-1:0]    gpr [NR_REG];
    logic [CW-1:0]      cnt [NR_REG];
    dec_t               dec_d;
    dec_t               out_q;
    logic               out_vld_q;

    inst_type_t         itype;
    logic [6:0]         opcode;
    logic [REG_SEL-1:0] rd;
    logic [REG_SEL-1:0] rs1;
    logic [REG_SEL-1:0] rs2;
    logic [XLEN-1:0]    imm;
    logic [XLEN-1:0]    rs1_val;
    logic [XLEN-1:0]    rs2_val;
    logic               use_rs1;
    logic               use_rs2;
    logic               dec_rd_wen;
    logic               out_wr;
    logic               rs1_haz;
    logic               rs2_haz;
    logic               rd_haz;
    logic [CW:0]        rd_pend;
    logic               accept;
    logic               out_fire;
    logic [NR_REG-1:0]  sb_inc;
    logic [NR_REG-1:0]  sb_dec;

    assign opcode = in_inst[6:0];
    assign rd     = in_inst[7 +: REG_SEL];
    assign rs1    = in_inst[15 +: REG_SEL];
    assign rs2    = in_inst[20 +: REG_SEL];

    always_comb begin
        itype = T_ILL;
        case (opcode)
            7'b0110011, 7'b0111011:                         itype = T_R;
            7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111: itype = T_I;
            7'b0100011:                                     itype = T_S;
            7'b1100011:                                     itype = T_B;
            7'b0110111, 7'b0010111:                         itype = T_U;
            7'b1101111:                                     itype = T_J;
            default: itype = (in_inst == 32'h0010_0073) ? T_SYS : T_ILL;
        endcase
    end

    always_comb begin
        imm = '0;
        case (itype)
            T_I: imm = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
            T_S: imm = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            T_B: imm = {{(XLEN-12){in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
            T_U: imm = {{(XLEN-32){in_inst[31]}}, in_inst[31:12], 12'b0};
            T_J: imm = {{(XLEN-20){in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    assign use_rs1    = (itype == T_R) || (itype == T_I) || (itype == T_S) || (itype == T_B);
    assign use_rs2    = (itype == T_R) || (itype == T_S) || (itype == T_B);
    assign dec_rd_wen = ((itype == T_R) || (itype == T_I) || (itype == T_U) || (itype == T_J))
                        && (rd != '0);

    // Write-first read: a same-cycle writeback wins over the stored value.
    assign rs1_val = (rs1 == '0) ? '0 : (wb_valid && wb_rd == rs1) ? wb_data : gpr[rs1];
    assign rs2_val = (rs2 == '0) ? '0 : (wb_valid && wb_rd == rs2) ? wb_data : gpr[rs2];

    always_comb begin
        dec_d        = '0;
        dec_d.pc     = in_pc;
        dec_d.itype  = itype;
        dec_d.opcode = opcode;
        dec_d.funct3 = in_inst[14:12];
        dec_d.funct7 = in_inst[31:25];
        dec_d.rd     = rd;
        dec_d.rd_wen = dec_rd_wen;
        dec_d.pc_wen = (itype == T_B) || (itype == T_J) || (opcode == 7'b1100111 && itype == T_I);
        dec_d.src1   = use_rs1 ? rs1_val : '0;
        dec_d.src2   = use_rs2 ? rs2_val : ((itype == T_I) ? imm : '0);
        dec_d.imm    = imm;
    end

    // The held output counts as a pending writer until it fires into cnt.
    assign out_wr  = out_vld_q && out_q.rd_wen;
    assign rs1_haz = use_rs1 && (rs1 != '0) &&
                     ((out_wr && out_q.rd == rs1) ||
                      (cnt[rs1] != '0 && !(cnt[rs1] == CW'(1) && wb_valid && wb_rd == rs1)));
    assign rs2_haz = use_rs2 && (rs2 != '0) &&
                     ((out_wr && out_q.rd == rs2) ||
                      (cnt[rs2] != '0 && !(cnt[rs2] == CW'(1) && wb_valid && wb_rd == rs2)));
    assign rd_pend = {1'b0, cnt[rd]} + {{CW{1'b0}}, (out_wr && out_q.rd == rd)};
    assign rd_haz  = dec_rd_wen && (rd_pend >= MAX_CNT);

    assign in_ready = rst && !(rs1_haz || rs2_haz || rd_haz || (out_vld_q && !out_ready) || flush);
    assign accept   = in_valid && in_ready;
    assign out_fire = out_vld_q && out_ready && !flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_vld_q <= 1'b0;
            out_q     <= '0;
        end else if (accept) begin
            out_vld_q <= 1'b1;
            out_q     <= dec_d;
        end else if (flush || out_fire) begin
            out_vld_q <= 1'b0;
        end
    end

    always_comb begin
        sb_inc = '0;
        sb_dec = '0;
        if (out_fire && out_q.rd_wen) sb_inc[out_q.rd] = 1'b1;
        if (wb_valid)                 sb_dec[wb_rd]    = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NR_REG; r++) cnt[r] <= '0;
        end else begin
            for (int r = 0; r < NR_REG; r++) begin
                if (sb_inc[r] && !sb_dec[r])
                    cnt[r] <= cnt[r] + CW'(1);
                else if (sb_dec[r] && !sb_inc[r] && cnt[r] != '0)
                    cnt[r] <= cnt[r] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NR_REG; r++) gpr[r] <= '0;
        end else if (wb_valid && wb_rd != '0) begin
            gpr[wb_rd] <= wb_data;
        end
    end

    assign out_valid  = out_vld_q;
    assign out_pc     = out_q.pc;
    assign out_type   = out_q.itype;
    assign out_opcode = out_q.opcode;
    assign out_funct3 = out_q.funct3;
    assign out_funct7 = out_q.funct7;
    assign out_rd     = out_q.rd;
    assign out_rd_wen = out_q.rd_wen;
    assign out_pc_wen = out_q.pc_wen;
    assign out_src1   = out_q.src1;
    assign out_src2   = out_q.src2;
    assign out_imm    = out_q.imm;

endmodule
